skin_region_stats: RTL
======================

Name: skin_region_stats

Overview:
- Reader on the output side of the skin binarization stage: consumes the binary skin mask stream (skin, de, hsync, vsync) and tracks pixel coordinates.
- Accumulates per-frame statistics: skin pixel count and skin bounding box.
- Publishes the previous frame's results, with a one-cycle valid strobe, at each frame boundary.
- Sits between skin_binarization and the hand-tracking control logic.

Parameters:
- X_W, 11, column counter width (max 2^X_W-1 columns)
- Y_W, 10, row counter width
- CNT_W, 21, skin pixel counter width

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; all state updates only when ce=1
- de_in  in  1  data enable from skin_binarization
- hsync_in  in  1  hsync from skin_binarization (unused for counting, registered only)
- vsync_in  in  1  vsync, active-high; rising edge = frame start
- skin  in  8  mask pixel; nonzero = skin
- skin_count  out  CNT_W  skin pixels in last complete frame
- x_min  out  X_W  bounding box left column
- x_max  out  X_W  bounding box right column
- y_min  out  Y_W  bounding box top row
- y_max  out  Y_W  bounding box bottom row
- empty  out  1  last frame had zero skin pixels
- result_valid  out  1  one-clk strobe: result registers just updated

Behaviour:
- Reset: all outputs 0, except empty=1. All counters and accumulators are 0. Internal vsync_q and de_q are 0. FSM is in WAIT_FRAME.
- Edge detection (ce=1 cycles only):
  - vs_rise = vsync_in & ~vsync_q
  - de_fall = ~de_in & de_q
- Column counter x:
  - increments on each ce cycle with de_in=1
  - cleared on de_fall and on vs_rise
  - saturates at all-ones
- Row counter y:
  - increments on de_fall
  - cleared on vs_rise
  - saturates at all-ones
- Skin pixel = de_in=1 and skin!=0 at coordinates (x, y).
  - On a skin pixel, count++ (saturating).
  - Box accumulators update: bx_min=min, bx_max=max, by_min=min, by_max=max.
  - First skin pixel of a frame loads all four box values directly.
- FSM states:
  - WAIT_FRAME: after reset; ignores pixels; on vs_rise goes to ACTIVE and clears accumulators; no result_valid.
  - ACTIVE: accumulates; on vs_rise latches accumulators into the output registers, pulses result_valid for exactly one clk, clears accumulators, and stays ACTIVE.
- Latency: outputs change on the same clk edge that samples vs_rise; result_valid is high in the following clk cycle only.
- Empty frame: empty=1, skin_count=0, x_min/x_max/y_min/y_max=0.
- Simultaneous vs_rise and skin pixel: the pixel belongs to the new frame at coordinate (0,0).
  - The accumulators are loaded with that pixel, not cleared to empty.
  - The latched result excludes the pixel.
- ce=0: no state change. result_valid still deasserts after its single clk.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded (WAIT_FRAME).
- Outputs hold between strobes.

Optional Feature:
- Macro SKIN_STATS_SUMS_EN.
- When defined, adds two outputs:
  - sum_x  out  CNT_W+X_W  sum of x over skin pixels of last frame
  - sum_y  out  CNT_W+Y_W  sum of y over skin pixels of last frame
- Sums are accumulated, latched and cleared alongside skin_count, and reset to 0. Software uses them for centroid = sum/count.
- When undefined, the ports and accumulators are absent; all other behaviour is identical.

Test Plan:
- Reset then a single vsync rise with no pixels -> FSM enters ACTIVE, no result_valid pulse, all outputs stay at reset values (empty=1).
- Frame of 8 columns x 4 rows with skin=255 only at (2,1) and (5,3), then vsync rise -> one result_valid; skin_count=2, x_min=2, x_max=5, y_min=1, y_max=3, empty=0 (sums 7/4 if SKIN_STATS_SUMS_EN).
- Full frame with skin=0, then vsync rise -> result_valid, skin_count=0, empty=1, box all 0.
- Skin pixel (skin=8'h01) presented in the same ce cycle as vsync rise -> latched count excludes it; the next frame reports count=1, box (0,0,0,0).
- ce toggled 0/1 every other clk during the frame of the 8x4 test -> results identical to the ce=1 run; result_valid width exactly one clk.
- rst_n pulsed low mid-frame after 3 skin pixels -> outputs return to 0 (empty=1) immediately; the next vsync rise produces no result_valid; the frame after that reports only its own pixels.

Source files
------------

// File: rtl/skin_region_stats.sv
// -----------------------------------------------------------------------------
// skin_region_stats
//   Per-frame statistics for the binary skin mask stream: skin pixel count and
//   bounding box of the skin pixels. At each frame boundary (vsync rising edge)
//   the finished frame's results are latched into the output registers and
//   result_valid pulses for one clk.
//
// Optional feature (macro SKIN_STATS_SUMS_EN):
//   Adds sum_x / sum_y outputs (sum of skin pixel coordinates) so software can
//   compute the centroid as sum/count.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   ce           clock enable; no state changes while low
//   de_in        data enable of the mask stream
//   hsync_in     hsync of the mask stream (registered only)
//   vsync_in     vsync, active high; rising edge starts a frame
//   skin[7:0]    mask pixel; nonzero = skin
//   skin_count   skin pixels in last complete frame
//   x_min/x_max  bounding box columns of last frame
//   y_min/y_max  bounding box rows of last frame
//   empty        last frame had no skin pixels
//   result_valid one-clk strobe after the result registers update
//   sum_x/sum_y  (SKIN_STATS_SUMS_EN only) coordinate sums of last frame
// -----------------------------------------------------------------------------
module skin_region_stats #(
    parameter int X_W   = 11,
    parameter int Y_W   = 10,
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             de_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [7:0]       skin,
    output logic [CNT_W-1:0] skin_count,
    output logic [X_W-1:0]   x_min,
    output logic [X_W-1:0]   x_max,
    output logic [Y_W-1:0]   y_min,
    output logic [Y_W-1:0]   y_max,
    output logic             empty,
    output logic             result_valid
`ifdef SKIN_STATS_SUMS_EN
    ,
    output logic [CNT_W+X_W-1:0] sum_x,
    output logic [CNT_W+Y_W-1:0] sum_y
`endif
);

    typedef enum logic {ST_WAIT_FRAME, ST_ACTIVE} state_t;

    state_t           r_state, w_state_nxt;
    logic             w_latch;

    logic             r_vsync_q, r_de_q, r_hsync_q;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;

    logic [CNT_W-1:0] r_cnt;
    logic [X_W-1:0]   r_bx_min, r_bx_max;
    logic [Y_W-1:0]   r_by_min, r_by_max;

    logic [CNT_W-1:0] r_skin_count;
    logic [X_W-1:0]   r_x_min, r_x_max;
    logic [Y_W-1:0]   r_y_min, r_y_max;
    logic             r_empty, r_valid;

    // Edges are qualified with ce so every consumer sees them only on
    // cycles where state is allowed to move.
    logic             w_vs_rise, w_de_fall, w_pix;
    logic [X_W-1:0]   w_px;
    logic [Y_W-1:0]   w_py;

    assign w_vs_rise = ce & vsync_in & ~r_vsync_q;
    assign w_de_fall = ce & ~de_in & r_de_q;
    assign w_pix     = de_in & (skin != 8'd0);
    // A pixel arriving with the vsync edge is the first pixel of the new frame.
    assign w_px      = w_vs_rise ? '0 : r_x;
    assign w_py      = w_vs_rise ? '0 : r_y;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_WAIT_FRAME;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            ST_WAIT_FRAME: if (w_vs_rise) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE:     if (w_vs_rise) w_latch = 1'b1;
            default:       w_state_nxt = ST_WAIT_FRAME;
        endcase
    end

    // ---------------- edge history + coordinates ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_q <= 1'b0;
            r_de_q    <= 1'b0;
            r_hsync_q <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
        end else if (ce) begin
            r_vsync_q <= vsync_in;
            r_de_q    <= de_in;
            r_hsync_q <= hsync_in;
            // On vs_rise the current pixel (if any) sits at column 0, so the
            // next column is 1.
            if (w_vs_rise)
                r_x <= {{(X_W-1){1'b0}}, de_in};
            else if (w_de_fall)
                r_x <= '0;
            else if (de_in && (r_x != '1))
                r_x <= r_x + 1'b1;

            if (w_vs_rise)
                r_y <= '0;
            else if (w_de_fall && (r_y != '1))
                r_y <= r_y + 1'b1;
        end
    end

    // ---------------- per-frame accumulators ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_bx_min <= '0;
            r_bx_max <= '0;
            r_by_min <= '0;
            r_by_max <= '0;
        end else if (w_vs_rise) begin
            // New frame: either empty, or loaded with the (0,0) pixel. The
            // box is all zero in both cases.
            r_cnt    <= {{(CNT_W-1){1'b0}}, w_pix};
            r_bx_min <= '0;
            r_bx_max <= '0;
            r_by_min <= '0;
            r_by_max <= '0;
        end else if (ce && (r_state == ST_ACTIVE) && w_pix) begin
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            // Count still zero means this is the frame's first skin pixel.
            if (r_cnt == '0) begin
                r_bx_min <= w_px;
                r_bx_max <= w_px;
                r_by_min <= w_py;
                r_by_max <= w_py;
            end else begin
                if (w_px < r_bx_min) r_bx_min <= w_px;
                if (w_px > r_bx_max) r_bx_max <= w_px;
                if (w_py < r_by_min) r_by_min <= w_py;
                if (w_py > r_by_max) r_by_max <= w_py;
            end
        end
    end

    // ---------------- result registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skin_count <= '0;
            r_x_min      <= '0;
            r_x_max      <= '0;
            r_y_min      <= '0;
            r_y_max      <= '0;
            r_empty      <= 1'b1;
            r_valid      <= 1'b0;
        end else begin
            // Not gated by ce: the strobe always drops after one clk.
            r_valid <= w_latch;
            if (w_latch) begin
                r_skin_count <= r_cnt;
                r_x_min      <= r_bx_min;
                r_x_max      <= r_bx_max;
                r_y_min      <= r_by_min;
                r_y_max      <= r_by_max;
                r_empty      <= (r_cnt == '0);
            end
        end
    end

    assign skin_count   = r_skin_count;
    assign x_min        = r_x_min;
    assign x_max        = r_x_max;
    assign y_min        = r_y_min;
    assign y_max        = r_y_max;
    assign empty        = r_empty;
    assign result_valid = r_valid;

`ifdef SKIN_STATS_SUMS_EN
    logic [CNT_W+X_W-1:0] r_acc_x, r_sum_x;
    logic [CNT_W+Y_W-1:0] r_acc_y, r_sum_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_x <= '0;
            r_acc_y <= '0;
            r_sum_x <= '0;
            r_sum_y <= '0;
        end else begin
            if (w_latch) begin
                r_sum_x <= r_acc_x;
                r_sum_y <= r_acc_y;
            end
            // A pixel on the vsync edge is at (0,0) and contributes nothing.
            if (w_vs_rise) begin
                r_acc_x <= '0;
                r_acc_y <= '0;
            end else if (ce && (r_state == ST_ACTIVE) && w_pix) begin
                r_acc_x <= r_acc_x + {{CNT_W{1'b0}}, w_px};
                r_acc_y <= r_acc_y + {{CNT_W{1'b0}}, w_py};
            end
        end
    end

    assign sum_x = r_sum_x;
    assign sum_y = r_sum_y;
`endif

endmodule
